// File: rtl/program_loader_if.sv
// Byte-stream handshake and IMEM write bus shared between a program_loader,
// its byte source and the instruction memory. The loader uses the slave view.
interface program_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream (length, N opcodes, XOR
// checksum), writes the opcodes into IMEM from address 0 and holds the CPU in
// reset until a frame passes its checksum.
// Optional feature macro: LOADER_FILL_EN -- after a good frame, write FILL_WORD
// to every IMEM entry the frame did not cover before releasing the CPU.
module program_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
`ifdef LOADER_FILL_EN
    ,
    parameter logic [DATA_W-1:0] FILL_WORD = 8'h00
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_start,
    program_loader_if.slave      bus,
    output logic                 cpu_reset,
    output logic                 done,
    output logic                 error
);

    localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);
`ifdef LOADER_FILL_EN
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_C  = (ADDR_W + 1)'(DEPTH - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
`ifdef LOADER_FILL_EN
        S_FILL,
`endif
        S_RUN,
        S_ERR
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] csum;
    logic              ready;
    logic              clr;
    logic              len_ld;
    logic              wr_data;
    logic              wr_fill;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign bus.in_ready   = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state decode plus state-derived outputs and datapath strobes
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        clr        = 1'b0;
        len_ld     = 1'b0;
        wr_data    = 1'b0;
        wr_fill    = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_next = S_LEN;
                    clr        = 1'b1;
                end
            end
            S_LEN: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_data == '0 || bus.in_data > DEPTH_B) begin
                        state_next = S_ERR;
                    end else begin
                        len_ld     = 1'b1;
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    wr_data = 1'b1;
                    if ((count + 1'b1) == len) state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_data == csum) begin
`ifdef LOADER_FILL_EN
                        state_next = (len == DEPTH_C) ? S_RUN : S_FILL;
`else
                        state_next = S_RUN;
`endif
                    end else begin
                        state_next = S_ERR;
                    end
                end
            end
`ifdef LOADER_FILL_EN
            S_FILL: begin
                wr_fill = 1'b1;
                if (count == LAST_C) state_next = S_RUN;
            end
`endif
            S_RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (load_start) begin
                    state_next = S_LEN;
                    clr        = 1'b1;
                end
            end
            S_ERR: begin
                error = 1'b1;
                if (load_start) begin
                    state_next = S_LEN;
                    clr        = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Frame datapath: length, running checksum, write counter and the
    // registered IMEM write port (one cycle behind the accepted byte)
    always_ff @(posedge clk) begin
        if (!reset) begin
            count   <= '0;
            len     <= '0;
            csum    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (clr) begin
                count <= '0;
                csum  <= '0;
            end
            if (len_ld) len <= bus.in_data[ADDR_W:0];
            if (wr_data) begin
                we_q    <= 1'b1;
                addr_q  <= count[ADDR_W-1:0];
                wdata_q <= bus.in_data;
                csum    <= csum ^ bus.in_data;
                count   <= count + 1'b1;
            end
`ifdef LOADER_FILL_EN
            if (wr_fill) begin
                we_q    <= 1'b1;
                addr_q  <= count[ADDR_W-1:0];
                wdata_q <= FILL_WORD;
                count   <= count + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: per-cycle vector table for the error paths,
// plus hand-written sequences for good frames, release timing and mid-frame reset.
module tb_program_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic load_start = 1'b0;
    logic cpu_reset, done, error;

    int errors = 0;
    int checks = 0;
    int writes = 0;
    logic [7:0] mem [16];

    program_loader_if #(.ADDR_W(4), .DATA_W(8)) itf ();

    program_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .bus        (itf.slave),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // IMEM model captures every write strobe
    always @(posedge clk) begin
        if (itf.imem_we) begin
            mem[itf.imem_addr] <= itf.imem_wdata;
            writes <= writes + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ls;
        logic        v;
        logic [7:0]  d;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [16:0] pk(input logic rdy, input logic we, input logic [3:0] a,
                                       input logic [7:0] wd, input logic dn, input logic er,
                                       input logic cr);
        return {rdy, we, a, wd, dn, er, cr};
    endfunction

    function automatic logic [16:0] outs();
        return {itf.in_ready, itf.imem_we, itf.imem_addr, itf.imem_wdata, done, error, cpu_reset};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Offer a byte, wait (bounded) for the handshake, then optionally idle
    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        itf.in_valid = 1'b1;
        itf.in_data  = b;
        while (!itf.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 for byte %0h", b);
        end
        @(posedge clk);
        @(negedge clk);
        if (gap > 0) begin
            itf.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    // Cycles from the checksum handshake until done rises (bounded)
    task automatic wait_done(output int n);
        n = 0;
        itf.in_valid = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [7:0] prog [14];
    logic [7:0] cs;
    int n;
    int w0;
    int exp_fill14, exp_fill3, exp_fill2, exp_w14;

    initial begin
        itf.in_valid = 1'b0;
        itf.in_data  = 8'h00;
        for (int unsigned i = 0; i < 16; i++) mem[i] = 8'hEE;
`ifdef LOADER_FILL_EN
        exp_fill14 = 2;  exp_fill3 = 13; exp_fill2 = 14; exp_w14 = 16;
`else
        exp_fill14 = 0;  exp_fill3 = 0;  exp_fill2 = 0;  exp_w14 = 14;
`endif

        // Frame 02,41,82 with bad checksum 00 (expected C3), then length 11 and 00
        tbl[0]  = '{1'b1, 1'b0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 0, 1)};
        tbl[1]  = '{1'b0, 1'b1, 8'h02, pk(1, 0, 4'h0, 8'h00, 0, 0, 1)};
        tbl[2]  = '{1'b1, 1'b1, 8'h41, pk(1, 0, 4'h0, 8'h00, 0, 0, 1)};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, pk(1, 1, 4'h0, 8'h41, 0, 0, 1)};
        tbl[4]  = '{1'b0, 1'b1, 8'h82, pk(1, 0, 4'h0, 8'h41, 0, 0, 1)};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, pk(1, 1, 4'h1, 8'h82, 0, 0, 1)};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, pk(0, 0, 4'h1, 8'h82, 0, 1, 1)};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, pk(0, 0, 4'h1, 8'h82, 0, 1, 1)};
        tbl[8]  = '{1'b0, 1'b1, 8'h11, pk(1, 0, 4'h1, 8'h82, 0, 0, 1)};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, pk(0, 0, 4'h1, 8'h82, 0, 1, 1)};
        tbl[10] = '{1'b1, 1'b0, 8'h00, pk(0, 0, 4'h1, 8'h82, 0, 1, 1)};
        tbl[11] = '{1'b0, 1'b1, 8'h00, pk(1, 0, 4'h1, 8'h82, 0, 0, 1)};
        tbl[12] = '{1'b0, 1'b0, 8'h00, pk(0, 0, 4'h1, 8'h82, 0, 1, 1)};
        tbl[13] = '{1'b0, 1'b1, 8'h55, pk(0, 0, 4'h1, 8'h82, 0, 1, 1)};

        prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                 8'h88, 8'h99, 8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'(pk(0, 0, 4'h0, 8'h00, 0, 0, 1)));
        reset = 1'b1;

        // Vector table, one cycle per entry
        for (int i = 0; i < 14; i++) begin
            load_start   = tbl[i].ls;
            itf.in_valid = tbl[i].v;
            itf.in_data  = tbl[i].d;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
            @(negedge clk);
        end
        load_start   = 1'b0;
        itf.in_valid = 1'b0;
        chk("err_frame_writes", 32'(writes), 32'd2);

        // Good 14-byte frame with random gaps and held valid
        w0 = writes;
        pulse_start();
        send(8'h0E, 0);
        cs = 8'h00;
        for (int i = 0; i < 14; i++) begin
            cs ^= prog[i];
            send(prog[i], int'($urandom_range(0, 2)));
        end
        send(cs, 0);
        wait_done(n);
        chk("rel14_cycles", 32'(n), 32'(exp_fill14));
        chk("rel14_flags", {29'd0, done, error, cpu_reset}, {29'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        chk("rel14_writes", 32'(writes - w0), 32'(exp_w14));
        for (int i = 0; i < 14; i++)
            chk($sformatf("mem14_%0d", i), 32'(mem[i]), 32'(prog[i]));

        // Reload from RUN: frame 03,AA,BB,CC,DD
        pulse_start();
        chk("reload_cpu_reset", {30'd0, cpu_reset, done}, {30'd0, 1'b1, 1'b0});
        send(8'h03, 0);
        send(8'hAA, 1);
        send(8'hBB, 0);
        send(8'hCC, 0);
        send(8'hDD, 0);
        wait_done(n);
        chk("rel3_cycles", 32'(n), 32'(exp_fill3));
        chk("rel3_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("mem3_0", 32'(mem[0]), 32'hAA);
        chk("mem3_1", 32'(mem[1]), 32'hBB);
        chk("mem3_2", 32'(mem[2]), 32'hCC);
`ifdef LOADER_FILL_EN
        for (int i = 3; i < 16; i++)
            chk($sformatf("fill3_%0d", i), 32'(mem[i]), 32'h00);
`else
        for (int i = 3; i < 14; i++)
            chk($sformatf("keep3_%0d", i), 32'(mem[i]), 32'(prog[i]));
        chk("keep3_14", 32'(mem[14]), 32'hEE);
`endif

        // Reset in the middle of DATA, then a clean reload
        pulse_start();
        send(8'h08, 0);
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), i % 2);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", 32'(outs()), 32'(pk(0, 0, 4'h0, 8'h00, 0, 0, 1)));
        reset = 1'b1;
        pulse_start();
        send(8'h02, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        wait_done(n);
        chk("rel2_cycles", 32'(n), 32'(exp_fill2));
        chk("rel2_flags", {29'd0, done, error, cpu_reset}, {29'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        chk("mem2_0", 32'(mem[0]), 32'h01);
        chk("mem2_1", 32'(mem[1]), 32'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
